spi_slave_responder: RTL and testbench



---
 rtl/spi_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 37 +++
 rtl/spi_slave_responder.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the mode-0 SPI slave responder.
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Sent whenever the host has not supplied a byte in time.
  localparam logic [7:0] IDLE_FILL = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } spi_slv_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pin synchronizer with one extra registered copy for edge detection.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    prev_d = sync_q[STAGES-1];
  end

  // RESET_VAL lets idle-high pins such as cs_bar come out of reset without a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave: oversampled pins, MSB-first rx/tx shifting, one-entry tx buffer.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              cs_bar,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL     = DATA_W'(IDLE_FILL);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (sclk_in),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (cs_bar),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_slv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              consume;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    consume       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          consume    = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Deselect wins over any coincident sclk edge and drops the partial word.
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            consume = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Consume looks only at the registered buffer state, so a same-cycle load never bypasses.
    if (consume) begin
      if (tx_ready_q) begin
        tx_shift_d    = FILL;
        tx_underrun_d = 1'b1;
      end else begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end
    end

    if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      tx_buf_q      <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      tx_buf_q      <= tx_buf_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // The tx register is cleared on deselect, so miso idles low without extra gating.
  assign miso        = tx_shift_q[DATA_W-1];
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = ~cs_level;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed plus randomized frames driven by a pin-level SPI master, checked against a byte-level buffer model.
module tb_spi_slave_responder;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk_in;
  logic       cs_bar;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk_in     (sclk_in),
    .cs_bar      (cs_bar),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] rxGot[$];
  int         urCount = 0;

  always @(negedge clk) begin
    if (rx_valid) rxGot.push_back(rx_data);
    if (tx_underrun) urCount++;
  end

  // Byte-level model: one-entry buffer plus the last completed received word.
  bit         mBufFull = 1'b0;
  logic [7:0] mBufVal  = 8'h00;
  logic [7:0] mLastRx  = 8'h00;
  logic [7:0] sendQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelConsume(output logic [7:0] v, output bit under);
    if (mBufFull) begin
      v        = mBufVal;
      under    = 1'b0;
      mBufFull = 1'b0;
    end else begin
      v     = 8'hFF;
      under = 1'b1;
    end
  endtask

  task automatic loadTx(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!mBufFull) begin
      mBufVal  = v;
      mBufFull = 1'b1;
    end
    checkOutput("tx_ready_after_load", tx_ready, !mBufFull);
  endtask

  // One frame of nBits taken MSB-first from sendQ; optional tx_load once the frame has started.
  task automatic applyStimulus(input int nBits, input bit midLoad, input logic [7:0] midVal,
                               input bit releaseCs);
    logic [7:0] expMiso[$];
    logic [7:0] v;
    logic [7:0] word;
    logic [7:0] got;
    bit         u;
    int         expUnder;
    int         ur0;
    int         nWords;

    nWords = nBits / 8;
    modelConsume(v, u);
    expMiso.push_back(v);
    expUnder = int'(u);
    ur0 = urCount;
    rxGot.delete();

    @(negedge clk);
    cs_bar = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    checkOutput("busy_in_frame", busy, 1);
    checkOutput("underrun_at_start", urCount - ur0, int'(u));
    checkOutput("tx_ready_after_cs_fall", tx_ready, !mBufFull);
    if (midLoad) loadTx(midVal);
    repeat (2) @(negedge clk);

    got = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      word = sendQ[i / 8];
      mosi = word[7 - (i % 8)];
      repeat (HALF) @(negedge clk);
      got = {got[6:0], miso};
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
      if ((i % 8) == 7) begin
        checkOutput("miso_word", got, expMiso[i / 8]);
        mLastRx = word;
        modelConsume(v, u);
        expMiso.push_back(v);
        expUnder += int'(u);
      end
    end
    repeat (HALF) @(negedge clk);

    if (releaseCs) begin
      cs_bar = 1'b1;
      mosi   = 1'b0;
      repeat (HALF) @(negedge clk);
      checkOutput("busy_after_cs_rise", busy, 0);
      checkOutput("miso_idle", miso, 0);
    end

    checkOutput("rx_valid_count", rxGot.size(), nWords);
    for (int w = 0; w < nWords && w < rxGot.size(); w++)
      checkOutput("rx_word", rxGot[w], sendQ[w]);
    checkOutput("rx_data_final", rx_data, mLastRx);
    checkOutput("underrun_total", urCount - ur0, expUnder);
  endtask

  initial begin
    int nW;
    bit ml;

    reset   = 1'b1;
    cs_bar  = 1'b1;
    sclk_in = 1'b0;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_miso", miso, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_underrun", tx_underrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single word with preloaded reply");
    loadTx(8'hA5);
    sendQ = '{8'h3C};
    applyStimulus(8, 1'b0, 8'h00, 1'b1);

    $display("[TB] two-word frame with reload after cs fall");
    loadTx(8'h11);
    sendQ = '{8'hF0, 8'h0F};
    applyStimulus(16, 1'b1, 8'h22, 1'b1);

    $display("[TB] underrun frame");
    sendQ = '{8'h5A};
    applyStimulus(8, 1'b0, 8'h00, 1'b1);

    $display("[TB] aborted partial word then full word");
    sendQ = '{8'hC3};
    applyStimulus(5, 1'b0, 8'h00, 1'b1);
    sendQ = '{8'h81};
    applyStimulus(8, 1'b0, 8'h00, 1'b1);

    $display("[TB] load while buffer full is ignored");
    loadTx(8'h99);
    loadTx(8'h55);
    sendQ = '{8'h24};
    applyStimulus(8, 1'b0, 8'h00, 1'b1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) loadTx(8'($urandom));
      nW = int'($urandom_range(1, 3));
      ml = ($urandom_range(0, 1) == 1);
      sendQ.delete();
      for (int w = 0; w < nW; w++) sendQ.push_back(8'($urandom));
      applyStimulus(nW * 8, ml, 8'($urandom), 1'b1);
    end

    $display("[TB] reset mid-frame");
    loadTx(8'h6B);
    sendQ = '{8'hE7};
    applyStimulus(4, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_miso", miso, 0);
    checkOutput("midreset_rx_data", rx_data, 0);
    checkOutput("midreset_rx_valid", rx_valid, 0);
    checkOutput("midreset_tx_ready", tx_ready, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_tx_underrun", tx_underrun, 0);
    cs_bar  = 1'b1;
    sclk_in = 1'b0;
    mosi    = 1'b0;
    repeat (4) @(negedge clk);
    reset    = 1'b0;
    mBufFull = 1'b0;
    mLastRx  = 8'h00;
    repeat (SYNC + 3) @(negedge clk);
    sendQ = '{8'h7E};
    applyStimulus(8, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
